// File: rtl/mips_step_datapath.sv
// Single-step MIPS datapath (regfile, ALU, PC); each key_ok rising edge runs IDLE->READ->EXEC->WB, done 3 clocks after the edge.
// Step edges arriving while busy are dropped, not queued; OVERFLOW_TRAP_EN adds ovf_flag and blocks writeback/PC on ADD/SUB overflow.
module mips_step_datapath #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_ok,
  input  logic [3:0]        sel,
  input  logic [RA_W-1:0]   data_1,
  input  logic [RA_W-1:0]   data_2,
  input  logic [RA_W-1:0]   dest,
  input  logic              use_imm,
  input  logic              wr_en,
  input  logic              branch,
  input  logic [PC_W-1:0]   offset,
  input  logic              load_pc,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_zero_flag,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
`ifdef OVERFLOW_TRAP_EN
  output logic              ovf_flag,
`endif
  output logic              done
);

  localparam int NREG = 1 << RA_W;
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t state_q, state_d;

  logic              key_prev;
  logic              step_edge;
  logic              accept;

  logic [3:0]        sel_q;
  logic [RA_W-1:0]   d1_q, d2_q, dest_q;
  logic              imm_q, we_q, br_q;
  logic [PC_W-1:0]   off_q;
  logic [DATA_W-1:0] din_q;

  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] add_v, sub_v;
  logic [SH_W-1:0]   shamt;
  logic              alu_ovf;
  logic              ovf_q;
  logic              commit;
  logic              taken;

  assign step_edge = key_ok & ~key_prev;
  // A simultaneous PC load takes priority and swallows the step.
  assign accept    = (state_q == S_IDLE) && step_edge && !load_pc;
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_a = (d1_q == '0) ? '0 : regs[d1_q];
  assign rd_b = (d2_q == '0) ? '0 : regs[d2_q];

  assign add_v = a_q + b_q;
  assign sub_v = a_q - b_q;
  assign shamt = b_q[SH_W-1:0];

  always_comb begin
    alu_res = b_q;
    case (sel_q)
      4'd0:    alu_res = add_v;
      4'd1:    alu_res = sub_v;
      4'd2:    alu_res = a_q & b_q;
      4'd3:    alu_res = a_q | b_q;
      4'd4:    alu_res = a_q ^ b_q;
      4'd5:    alu_res = ~(a_q | b_q);
      4'd6:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'd7:    alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
      4'd8:    alu_res = a_q << shamt;
      4'd9:    alu_res = a_q >> shamt;
      4'd10:   alu_res = DATA_W'($signed(a_q) >>> shamt);
      4'd11:   alu_res = b_q << (DATA_W / 2);
      default: alu_res = b_q;
    endcase
  end

  // Signed overflow: operands' signs make the true result unrepresentable.
  always_comb begin
    alu_ovf = 1'b0;
    if (sel_q == 4'd0)
      alu_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (add_v[DATA_W-1] != a_q[DATA_W-1]);
    else if (sel_q == 4'd1)
      alu_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (sub_v[DATA_W-1] != a_q[DATA_W-1]);
  end

`ifdef OVERFLOW_TRAP_EN
  assign commit = !ovf_q;
`else
  assign commit = 1'b1;
`endif

  assign taken = br_q && (res_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev      <= 1'b1;
      sel_q         <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      dest_q        <= '0;
      imm_q         <= 1'b0;
      we_q          <= 1'b0;
      br_q          <= 1'b0;
      off_q         <= '0;
      din_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_q         <= '0;
      ovf_q         <= 1'b0;
      alu_out       <= '0;
      alu_zero_flag <= 1'b0;
      pc            <= '0;
      done          <= 1'b0;
`ifdef OVERFLOW_TRAP_EN
      ovf_flag      <= 1'b0;
`endif
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      key_prev <= key_ok;
      done     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_pc) begin
            pc <= data_in[PC_W-1:0];
          end else if (step_edge) begin
            sel_q  <= sel;
            d1_q   <= data_1;
            d2_q   <= data_2;
            dest_q <= dest;
            imm_q  <= use_imm;
            we_q   <= wr_en;
            br_q   <= branch;
            off_q  <= offset;
            din_q  <= data_in;
`ifdef OVERFLOW_TRAP_EN
            ovf_flag <= 1'b0;
`endif
          end
        end
        S_READ: begin
          a_q <= rd_a;
          b_q <= imm_q ? din_q : rd_b;
        end
        S_EXEC: begin
          res_q <= alu_res;
          ovf_q <= alu_ovf;
        end
        S_WB: begin
          alu_out       <= res_q;
          alu_zero_flag <= (res_q == '0);
          done          <= 1'b1;
          if (commit) begin
            if (we_q && dest_q != '0) regs[dest_q] <= res_q;
            pc <= taken ? (pc + PC_W'(1) + off_q) : (pc + PC_W'(1));
          end
`ifdef OVERFLOW_TRAP_EN
          else begin
            ovf_flag <= 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_step_datapath.sv
// Directed bench for mips_step_datapath (DATA_W=16, RA_W=3, PC_W=8); overflow checks follow OVERFLOW_TRAP_EN.
module tb_mips_step_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_ok;
  logic [3:0]  sel;
  logic [2:0]  data_1, data_2, dest;
  logic        use_imm, wr_en, branch, load_pc;
  logic [7:0]  offset;
  logic [15:0] data_in;
  logic [15:0] alu_out;
  logic        alu_zero_flag;
  logic [7:0]  pc;
  logic        busy, done;
`ifdef OVERFLOW_TRAP_EN
  logic        ovf_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_pc;

  always #5 clk = ~clk;

  mips_step_datapath #(.DATA_W(16), .RA_W(3), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .key_ok(key_ok), .sel(sel),
    .data_1(data_1), .data_2(data_2), .dest(dest),
    .use_imm(use_imm), .wr_en(wr_en), .branch(branch), .offset(offset),
    .load_pc(load_pc), .data_in(data_in),
    .alu_out(alu_out), .alu_zero_flag(alu_zero_flag), .pc(pc), .busy(busy),
`ifdef OVERFLOW_TRAP_EN
    .ovf_flag(ovf_flag),
`endif
    .done(done)
  );

  // Drives one step and reports how many edges after the sampling edge done appeared (-1 on timeout).
  task automatic do_step(input logic [3:0] s, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic imm, input logic we, input logic br,
                         input logic [7:0] off, input logic [15:0] din, output int lat);
    key_ok = 1'b0;
    @(posedge clk); #1;
    sel = s; data_1 = a; data_2 = b; dest = d; use_imm = imm;
    wr_en = we; branch = br; offset = off; data_in = din; key_ok = 1'b1;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      key_ok = 1'b0;
      if (done) begin lat = n; break; end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    @(posedge clk); #1;
    load_pc = 1'b1; data_in = v;
    @(posedge clk); #1;
    load_pc = 1'b0;
  endtask

  task automatic test_reset;
    logic seen_busy;
    rst = 1'b1; key_ok = 1'b1; sel = 4'd0; data_1 = 3'd0; data_2 = 3'd0; dest = 3'd0;
    use_imm = 1'b0; wr_en = 1'b0; branch = 1'b0; load_pc = 1'b0; offset = 8'h00; data_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (alu_zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", alu_zero_flag); end
    rst = 1'b0;
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen_busy = 1'b1;
    end
    checks++; if (seen_busy !== 1'b0) begin errors++; $display("FAIL held_key_step: got %b expected 0", seen_busy); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
    checks++; if (alu_out !== 16'h0000) begin errors++; $display("FAIL reset_alu: got %h expected 0000", alu_out); end
    key_ok = 1'b0;
    exp_pc = 8'h00;
  endtask

  task automatic test_load_and_add;
    int lat;
    do_load(16'h0005);
    exp_pc = 8'h05;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL load_pc: got %h expected %h", pc, exp_pc); end
    do_step(4'd0, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0012, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (lat !== 3) begin errors++; $display("FAIL step_latency: got %0d expected 3", lat); end
    checks++; if (alu_out !== 16'h0012) begin errors++; $display("FAIL add_imm: got %h expected 0012", alu_out); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL add_pc: got %h expected %h", pc, exp_pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
    // Back-to-back step reads r1 right after its write.
    do_step(4'd0, 3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (alu_out !== 16'h0012) begin errors++; $display("FAIL r1_readback: got %h expected 0012", alu_out); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL readback_pc: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_branch;
    int lat;
    do_load(16'h0006);
    do_step(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'hFE, 16'h0000, lat);
    checks++; if (alu_zero_flag !== 1'b1) begin errors++; $display("FAIL sub_zero: got %b expected 1", alu_zero_flag); end
    checks++; if (pc !== 8'h05) begin errors++; $display("FAIL branch_back: got %h expected 05", pc); end
    do_load(16'h00FF);
    do_step(4'd1, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h7F, 16'h0000, lat);
    checks++; if (pc !== 8'h7F) begin errors++; $display("FAIL branch_wrap: got %h expected 7f", pc); end
    do_step(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h10, 16'h0001, lat);
    checks++; if (alu_zero_flag !== 1'b0) begin errors++; $display("FAIL nz_flag: got %b expected 0", alu_zero_flag); end
    checks++; if (pc !== 8'h80) begin errors++; $display("FAIL branch_not_taken: got %h expected 80", pc); end
    exp_pc = 8'h80;
  endtask

  task automatic test_r0;
    int lat;
    do_step(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h00AA, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (alu_out !== 16'h00AA) begin errors++; $display("FAIL r0_write_alu: got %h expected 00aa", alu_out); end
    do_step(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (alu_out !== 16'h0000) begin errors++; $display("FAIL r0_reads_zero: got %h expected 0000", alu_out); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL r0_pc: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_back_to_back;
    int dones;
    key_ok = 1'b0;
    @(posedge clk); #1;
    sel = 4'd0; data_1 = 3'd0; use_imm = 1'b1; wr_en = 1'b0; branch = 1'b0; data_in = 16'h0005;
    key_ok = 1'b1;
    @(posedge clk); #1;
    key_ok = 1'b0; load_pc = 1'b1; data_in = 16'h0033;
    @(posedge clk); #1;
    key_ok = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      load_pc = 1'b0;
      if (done) dones++;
    end
    exp_pc = exp_pc + 8'd1;
    checks++; if (dones !== 1) begin errors++; $display("FAIL busy_edge_ignored: got %0d dones expected 1", dones); end
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL load_while_busy: got %h expected %h", pc, exp_pc); end
    checks++; if (alu_out !== 16'h0005) begin errors++; $display("FAIL latched_imm: got %h expected 0005", alu_out); end
    // Load and step on the same edge: load wins.
    key_ok = 1'b0;
    @(posedge clk); #1;
    key_ok = 1'b1; load_pc = 1'b1; data_in = 16'h0040;
    @(posedge clk); #1;
    load_pc = 1'b0;
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL load_beats_step: got %h expected 40", pc); end
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL step_dropped: got %0d active cycles expected 0", dones); end
    key_ok = 1'b0;
    exp_pc = 8'h40;
  endtask

  task automatic test_alu_ops;
    int lat;
    do_step(4'd0, 3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 8'h00, 16'h8000, lat);
    do_step(4'd0, 3'd0, 3'd0, 3'd3, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0001, lat);
    do_step(4'd6, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    checks++; if (alu_out !== 16'h0001) begin errors++; $display("FAIL slt: got %h expected 0001", alu_out); end
    do_step(4'd7, 3'd2, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    checks++; if (alu_out !== 16'h0000) begin errors++; $display("FAIL sltu: got %h expected 0000", alu_out); end
    do_step(4'd10, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0004, lat);
    checks++; if (alu_out !== 16'hF800) begin errors++; $display("FAIL sra: got %h expected f800", alu_out); end
    do_step(4'd9, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0004, lat);
    checks++; if (alu_out !== 16'h0800) begin errors++; $display("FAIL srl: got %h expected 0800", alu_out); end
    do_step(4'd8, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h000F, lat);
    checks++; if (alu_out !== 16'h8000) begin errors++; $display("FAIL sll: got %h expected 8000", alu_out); end
    do_step(4'd11, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0034, lat);
    checks++; if (alu_out !== 16'h3400) begin errors++; $display("FAIL lui: got %h expected 3400", alu_out); end
    do_step(4'd5, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    checks++; if (alu_out !== 16'hFFFF) begin errors++; $display("FAIL nor: got %h expected ffff", alu_out); end
    do_step(4'd4, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'h8001, lat);
    checks++; if (alu_out !== 16'h0001) begin errors++; $display("FAIL xor: got %h expected 0001", alu_out); end
    do_step(4'd14, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 16'hBEEF, lat);
    checks++; if (alu_out !== 16'hBEEF) begin errors++; $display("FAIL pass_b: got %h expected beef", alu_out); end
    exp_pc = exp_pc + 8'd11;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL alu_pc: got %h expected %h", pc, exp_pc); end
  endtask

  task automatic test_overflow;
    int lat;
    do_step(4'd0, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b0, 8'h00, 16'h7FFF, lat);
    exp_pc = exp_pc + 8'd1;
    do_step(4'd0, 3'd4, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0001, lat);
    checks++; if (alu_out !== 16'h8000) begin errors++; $display("FAIL ovf_alu: got %h expected 8000", alu_out); end
`ifdef OVERFLOW_TRAP_EN
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ovf_pc_hold: got %h expected %h", pc, exp_pc); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL ovf_flag_set: got %b expected 1", ovf_flag); end
    do_step(4'd0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (alu_out !== 16'h0000) begin errors++; $display("FAIL ovf_no_write: got %h expected 0000", alu_out); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_flag_clear: got %b expected 0", ovf_flag); end
`else
    exp_pc = exp_pc + 8'd1;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, exp_pc); end
    do_step(4'd0, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, lat);
    exp_pc = exp_pc + 8'd1;
    checks++; if (alu_out !== 16'h8000) begin errors++; $display("FAIL wrap_write: got %h expected 8000", alu_out); end
`endif
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL ovf_end_pc: got %h expected %h", pc, exp_pc); end
  endtask

  initial begin
    test_reset();
    test_load_and_add();
    test_branch();
    test_r0();
    test_back_to_back();
    test_alu_ops();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
